// File: rtl/pipe_phy_pkg.sv
// rtl/pipe_phy_pkg.sv - shared types and encodings for the PIPE PHY responder
package pipe_phy_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        RATE_WAIT,
        RATE_ACK,
        PD_WAIT,
        DETECT
    } phy_state_t;

    localparam logic [3:0] PD_P0  = 4'd0;
    localparam logic [3:0] PD_P0S = 4'd1;
    localparam logic [3:0] PD_P1  = 4'd2;
    localparam logic [3:0] PD_P2  = 4'd3;

    localparam logic [2:0] RXS_OK       = 3'b000;
    localparam logic [2:0] RXS_DETECTED = 3'b011;

    localparam int LAT_W = 16;

    // A zero latency would leave the timer done on load, so it is promoted to one cycle.
    function automatic logic [LAT_W-1:0] lat_norm(input int lat);
        return (lat < 1) ? LAT_W'(1) : LAT_W'(lat);
    endfunction

endpackage

// File: rtl/pipe_phy_lat_timer.sv
// rtl/pipe_phy_lat_timer.sv - loadable down-counter with done flag for handshake latencies
module pipe_phy_lat_timer
    import pipe_phy_pkg::*;
#(
    parameter logic [LAT_W-1:0] RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pipe_phy_responder.sv
// rtl/pipe_phy_responder.sv - behavioural PHY side of the PIPE control handshakes
module pipe_phy_responder
    import pipe_phy_pkg::*;
#(
    parameter int LANESNUMBER = 16,
    parameter int RESET_LAT   = 8,
    parameter int DETECT_LAT  = 4,
    parameter int PD_LAT      = 2,
    parameter int RATE_LAT    = 6,
    parameter int RX_PRESENT  = 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
    input  logic [LANESNUMBER-1:0]   TxElecIdle,
    input  logic [4*LANESNUMBER-1:0] PowerDown,
    input  logic [3:0]               Rate,
    input  logic                     PclkChangeAck,
    output logic [LANESNUMBER-1:0]   PhyStatus,
    output logic [3*LANESNUMBER-1:0] RxStatus,
    output logic [LANESNUMBER-1:0]   RxElectricalIdle,
    output logic                     PclkChangeOk
);

    localparam logic [LAT_W-1:0] RST_L    = lat_norm(RESET_LAT);
    localparam logic [LAT_W-1:0] DET_L    = lat_norm(DETECT_LAT);
    localparam logic [LAT_W-1:0] PD_L     = lat_norm(PD_LAT);
    localparam logic [LAT_W-1:0] RATE_L   = lat_norm(RATE_LAT);
    localparam logic [2:0]       DET_CODE = (RX_PRESENT != 0) ? RXS_DETECTED : RXS_OK;

    phy_state_t               state;
    logic [3:0]               rate_q;
    logic [4*LANESNUMBER-1:0] pd_q;
    logic                     det_flag;
    logic [LANESNUMBER-1:0]   det_prev;

    logic             rate_chg;
    logic             pd_chg;
    logic             det_set;
    logic             det_pend;
    logic             tmr_load;
    logic [LAT_W-1:0] tmr_val;
    logic             tmr_done;

    // Only a rising detect request while lane 0 sits in P1 is a receiver detect; otherwise it is loopback.
    assign det_set  = (|(TxDetectRx_Loopback & ~det_prev)) &&
                      (PowerDown[3:0] == PD_P1) && (state != RST_HOLD);
    assign det_pend = det_flag | det_set;
    assign rate_chg = (Rate != rate_q);
    assign pd_chg   = (PowerDown != pd_q);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = PD_L;
        if (state == IDLE) begin
            if (rate_chg) begin
                tmr_load = 1'b1;
                tmr_val  = RATE_L;
            end else if (pd_chg) begin
                tmr_load = 1'b1;
                tmr_val  = PD_L;
            end else if (det_pend) begin
                tmr_load = 1'b1;
                tmr_val  = DET_L;
            end
        end
    end

    pipe_phy_lat_timer #(
        .RST_VAL (RST_L)
    ) u_timer (
        .clk      (CLK),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state            <= RST_HOLD;
            PhyStatus        <= '1;
            RxStatus         <= '0;
            RxElectricalIdle <= '1;
            PclkChangeOk     <= 1'b0;
            pd_q             <= {LANESNUMBER{PD_P1}};
            rate_q           <= 4'd0;
            det_flag         <= 1'b0;
            det_prev         <= '0;
        end else begin
            det_prev         <= TxDetectRx_Loopback;
            RxElectricalIdle <= (state == RST_HOLD) ? '1 : TxElecIdle;
            RxStatus         <= '0;
            PhyStatus        <= '0;
            det_flag         <= det_flag | det_set;
            case (state)
                RST_HOLD: begin
                    if (tmr_done) begin
                        rate_q <= Rate;
                        pd_q   <= PowerDown;
                        state  <= IDLE;
                    end else begin
                        PhyStatus <= '1;
                    end
                end
                IDLE: begin
                    if (rate_chg) begin
                        state <= RATE_WAIT;
                    end else if (pd_chg) begin
                        state <= PD_WAIT;
                    end else if (det_pend) begin
                        state <= DETECT;
                    end
                end
                RATE_WAIT: begin
                    if (tmr_done) begin
                        PclkChangeOk <= 1'b1;
                        state        <= RATE_ACK;
                    end
                end
                RATE_ACK: begin
                    if (PclkChangeAck) begin
                        PclkChangeOk <= 1'b0;
                        PhyStatus    <= '1;
                        rate_q       <= Rate;
                        state        <= IDLE;
                    end
                end
                PD_WAIT: begin
                    if (tmr_done) begin
                        PhyStatus <= '1;
                        pd_q      <= PowerDown;
                        state     <= IDLE;
                    end
                end
                DETECT: begin
                    if (tmr_done) begin
                        PhyStatus <= '1;
                        RxStatus  <= {LANESNUMBER{DET_CODE}};
                        // A fresh edge landing on the result cycle stays pending.
                        det_flag  <= det_set;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
